// File: rtl/i2s_clk_ctrl.sv
// -----------------------------------------------------------------------------
// i2s_clk_ctrl
//
// Master clock and frame sequencer for the i2s datapath. Divides the system
// clock down to the codec master clock (mclk), the serial bit clock (sclk) and
// the word select (lrck). Framing starts phase-aligned to mclk and stops only
// on a frame boundary, so the codec never sees a partial frame.
//
// Ports
//   clk_i         system clock
//   rst_i         asynchronous, active-high reset
//   en_i          framing enable (level, sampled every clk)
//   mclk_o        codec master clock, free-running out of reset
//   sclk_o        serial bit clock
//   lrck_o        word select, 0 = left, 1 = right
//   sclk_rise_o   one-clk pulse in the cycle sclk_o goes 0->1
//   sclk_fall_o   one-clk pulse in the cycle sclk_o goes 1->0
//   frame_start_o one-clk pulse in the first cycle of each frame
//   running_o     high from the first RUN cycle through the last DRAIN cycle
//   frame_cnt_o   completed frames since reset, wraps
// -----------------------------------------------------------------------------
module i2s_clk_ctrl #(
    parameter int unsigned MCLK_DIV    = 4,   // clk cycles per mclk period, even, >= 2
    parameter int unsigned SCLK_DIV    = 8,   // mclk periods per sclk period, >= 1
    parameter int unsigned BITS_PER_CH = 32,  // sclk periods per channel half-frame
    parameter int unsigned FCNT_WIDTH  = 16   // frame counter width
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    output logic                  mclk_o,
    output logic                  sclk_o,
    output logic                  lrck_o,
    output logic                  sclk_rise_o,
    output logic                  sclk_fall_o,
    output logic                  frame_start_o,
    output logic                  running_o,
    output logic [FCNT_WIDTH-1:0] frame_cnt_o
);

    // clk cycles per sclk period, and per full stereo frame
    localparam int unsigned SclkPeriod = MCLK_DIV * SCLK_DIV;
    localparam int unsigned FrameLen   = 2 * BITS_PER_CH * SclkPeriod;
    localparam int unsigned MW         = (MCLK_DIV > 1) ? $clog2(MCLK_DIV) : 1;
    localparam int unsigned FW         = (FrameLen > 1) ? $clog2(FrameLen) : 1;

    localparam logic [MW-1:0] MclkLast = MW'(MCLK_DIV - 1);
    localparam logic [MW-1:0] MclkHalf = MW'(MCLK_DIV / 2);
    localparam logic [FW-1:0] FcntLast = FW'(FrameLen - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    state_e                  state_q, state_d;
    logic [MW-1:0]           mclk_cnt_q, mclk_cnt_d;
    logic [FW-1:0]           fcnt_q, fcnt_d;
    logic [FCNT_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;
    logic                    frame_done;

    logic                    mclk_q;
    logic                    sclk_q, sclk_d;
    logic                    lrck_q, lrck_d;
    logic                    sclk_rise_q, sclk_fall_q;
    logic                    frame_start_q;
    logic                    running_q;

    int unsigned             fidx;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        frame_done = 1'b0;

        // mclk divider free-runs in every state so the codec PLL stays locked
        if (mclk_cnt_q == MclkLast) begin
            mclk_cnt_d = '0;
        end else begin
            mclk_cnt_d = mclk_cnt_q + MW'(1);
        end

        unique case (state_q)
            StIdle: begin
                fcnt_d = '0;
                // Enter RUN so the first frame cycle coincides with mclk_cnt == 0
                if (en_i && (mclk_cnt_q == MclkLast)) begin
                    state_d = StRun;
                end
            end

            StRun: begin
                if (fcnt_q == FcntLast) begin
                    frame_done = 1'b1;
                    fcnt_d     = '0;
                    // Frame just completed: nothing is left to drain
                    if (!en_i) begin
                        state_d = StIdle;
                    end
                end else begin
                    fcnt_d = fcnt_q + FW'(1);
                    if (!en_i) begin
                        state_d = StDrain;
                    end
                end
            end

            StDrain: begin
                if (fcnt_q == FcntLast) begin
                    frame_done = 1'b1;
                    fcnt_d     = '0;
                    state_d    = en_i ? StRun : StIdle;
                end else begin
                    fcnt_d = fcnt_q + FW'(1);
                    // Resume without disturbing the bit/frame phase
                    if (en_i) begin
                        state_d = StRun;
                    end
                end
            end

            default: begin
                state_d = StIdle;
                fcnt_d  = '0;
            end
        endcase
    end

    always_comb begin
        if (frame_done) begin
            frame_cnt_d = frame_cnt_q + FCNT_WIDTH'(1);
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // -------------------------------------------------------------------------
    // Derived clocks, computed from the next frame position so the registered
    // outputs line up with fcnt_q in the same cycle.
    // -------------------------------------------------------------------------
    assign fidx = 32'(fcnt_d);

    always_comb begin
        sclk_d = 1'b0;
        lrck_d = 1'b0;
        if (state_d != StIdle) begin
            sclk_d = (fidx % SclkPeriod) >= (SclkPeriod / 2);
            // Changes at a multiple of SclkPeriod, i.e. on an sclk falling edge
            lrck_d = (fidx / SclkPeriod) >= BITS_PER_CH;
        end
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            mclk_cnt_q    <= '0;
            fcnt_q        <= '0;
            frame_cnt_q   <= '0;
            mclk_q        <= 1'b0;
            sclk_q        <= 1'b0;
            lrck_q        <= 1'b0;
            sclk_rise_q   <= 1'b0;
            sclk_fall_q   <= 1'b0;
            frame_start_q <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            mclk_cnt_q    <= mclk_cnt_d;
            fcnt_q        <= fcnt_d;
            frame_cnt_q   <= frame_cnt_d;
            // mclk follows the divider with one register stage of latency
            mclk_q        <= (mclk_cnt_q >= MclkHalf);
            sclk_q        <= sclk_d;
            lrck_q        <= lrck_d;
            // Strobes use the same next value as sclk_q, so they mark the exact
            // cycle the sclk register changes (including the IDLE entry fall)
            sclk_rise_q   <= sclk_d & ~sclk_q;
            sclk_fall_q   <= ~sclk_d & sclk_q;
            frame_start_q <= (state_d == StRun) && (fcnt_d == '0);
            running_q     <= (state_d != StIdle);
        end
    end

    assign mclk_o        = mclk_q;
    assign sclk_o        = sclk_q;
    assign lrck_o        = lrck_q;
    assign sclk_rise_o   = sclk_rise_q;
    assign sclk_fall_o   = sclk_fall_q;
    assign frame_start_o = frame_start_q;
    assign running_o     = running_q;
    assign frame_cnt_o   = frame_cnt_q;

endmodule

// File: tb/tb_i2s_clk_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for i2s_clk_ctrl. Two instances: the default configuration (A) and
// a small one (B: MCLK_DIV=2, SCLK_DIV=1, BITS_PER_CH=16). A reference model
// pushes expected outputs into a queue each cycle; they are popped and compared
// after the clock edge. Frame/bit timing monitors and a vector table anchored
// to the first frame_start of A check the boundary behaviour directly.
// -----------------------------------------------------------------------------
module tb_i2s_clk_ctrl;

    logic        clk;
    logic        rst;
    logic        en_a, en_b;

    logic        mclk_a, sclk_a, lrck_a, rise_a, fall_a, fs_a, run_a;
    logic [15:0] fcnt_a;
    logic        mclk_b, sclk_b, lrck_b, rise_b, fall_b, fs_b, run_b;
    logic [15:0] fcnt_b;

    logic [22:0] vec_a, vec_b;
    assign vec_a = {mclk_a, sclk_a, lrck_a, rise_a, fall_a, fs_a, run_a, fcnt_a};
    assign vec_b = {mclk_b, sclk_b, lrck_b, rise_b, fall_b, fs_b, run_b, fcnt_b};

    i2s_clk_ctrl u_dut_a (
        .clk_i         (clk),
        .rst_i         (rst),
        .en_i          (en_a),
        .mclk_o        (mclk_a),
        .sclk_o        (sclk_a),
        .lrck_o        (lrck_a),
        .sclk_rise_o   (rise_a),
        .sclk_fall_o   (fall_a),
        .frame_start_o (fs_a),
        .running_o     (run_a),
        .frame_cnt_o   (fcnt_a)
    );

    i2s_clk_ctrl #(
        .MCLK_DIV    (2),
        .SCLK_DIV    (1),
        .BITS_PER_CH (16),
        .FCNT_WIDTH  (16)
    ) u_dut_b (
        .clk_i         (clk),
        .rst_i         (rst),
        .en_i          (en_b),
        .mclk_o        (mclk_b),
        .sclk_o        (sclk_b),
        .lrck_o        (lrck_b),
        .sclk_rise_o   (rise_b),
        .sclk_fall_o   (fall_b),
        .frame_start_o (fs_b),
        .running_o     (run_b),
        .frame_cnt_o   (fcnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------------
    // Bookkeeping
    // ---------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    typedef struct {
        int mcnt;
        int st;     // 0 idle, 1 run, 2 drain
        int pos;
        int frames;
        bit mclk, sclk, lrck, rise, fall, fs, run;
    } mdl_t;

    mdl_t m_a, m_b;
    logic [22:0] q_a[$];
    logic [22:0] q_b[$];

    function automatic mdl_t model_step(input int mdiv, input int sdiv, input int bpc,
                                        input bit r, input bit e, input mdl_t m);
        mdl_t n;
        int   p;
        int   f;
        bit   act;
        p = mdiv * sdiv;
        f = 2 * bpc * p;
        n = m;
        if (r) begin
            n = '{default: 0};
            return n;
        end
        n.mclk = (m.mcnt >= mdiv / 2);
        n.mcnt = (m.mcnt + 1) % mdiv;
        case (m.st)
            0: begin
                n.pos = 0;
                if (e && m.mcnt == mdiv - 1) n.st = 1;
            end
            1: begin
                if (m.pos == f - 1) begin
                    n.frames = (m.frames + 1) % 65536;
                    n.pos    = 0;
                    if (!e) n.st = 0;
                end else begin
                    n.pos = m.pos + 1;
                    if (!e) n.st = 2;
                end
            end
            default: begin
                if (m.pos == f - 1) begin
                    n.frames = (m.frames + 1) % 65536;
                    n.pos    = 0;
                    n.st     = e ? 1 : 0;
                end else begin
                    n.pos = m.pos + 1;
                    if (e) n.st = 1;
                end
            end
        endcase
        act    = (n.st != 0);
        n.sclk = act && ((n.pos % p) >= p / 2);
        n.lrck = act && ((n.pos / p) >= bpc);
        n.rise = n.sclk && !m.sclk;
        n.fall = !n.sclk && m.sclk;
        n.fs   = (n.st == 1) && (n.pos == 0);
        n.run  = act;
        return n;
    endfunction

    function automatic logic [22:0] pack_m(input mdl_t m);
        logic [15:0] fr;
        fr = 16'(m.frames);
        return {m.mclk, m.sclk, m.lrck, m.rise, m.fall, m.fs, m.run, fr};
    endfunction

    // ---------------------------------------------------------------------
    // Timing monitors (expected distances written straight from the clock plan)
    // ---------------------------------------------------------------------
    int last_fs[2];
    int rises[2];
    bit first_rise[2];
    bit lrck_prev[2];

    task automatic mon_reset();
        for (int i = 0; i < 2; i++) begin
            last_fs[i]    = -1;
            rises[i]      = 0;
            first_rise[i] = 1'b1;
            lrck_prev[i]  = 1'b0;
        end
    endtask

    task automatic monitor(input int id, input logic [22:0] v);
        int half, lr_dist, frame, rpf;
        half    = (id == 0) ? 16 : 1;
        lr_dist = (id == 0) ? 1024 : 32;
        frame   = (id == 0) ? 2048 : 64;
        rpf     = (id == 0) ? 64 : 32;
        if (!v[16]) last_fs[id] = -1;
        if (v[19]) begin
            rises[id]++;
            if (last_fs[id] >= 0 && !first_rise[id]) begin
                check($sformatf("first_rise_dist_%0d", id), cyc - last_fs[id], half);
                first_rise[id] = 1'b1;
            end
        end
        if (v[20] != lrck_prev[id]) begin
            check($sformatf("lrck_on_fall_%0d", id), v[18], 1);
            if (v[20] && last_fs[id] >= 0)
                check($sformatf("lrck_dist_%0d", id), cyc - last_fs[id], lr_dist);
        end
        lrck_prev[id] = v[20];
        if (v[17]) begin
            if (last_fs[id] >= 0) begin
                check($sformatf("fs_gap_%0d", id), cyc - last_fs[id], frame);
                check($sformatf("rises_per_frame_%0d", id), rises[id], rpf);
            end
            last_fs[id]    = cyc;
            rises[id]      = 0;
            first_rise[id] = 1'b0;
        end
    endtask

    // One clock: model predicts, DUT is sampled 1 time unit after the edge
    task automatic tick();
        en_b = ((cyc / 150) % 3) != 2;
        m_a  = model_step(4, 8, 32, rst, en_a, m_a);
        m_b  = model_step(2, 1, 16, rst, en_b, m_b);
        q_a.push_back(pack_m(m_a));
        q_b.push_back(pack_m(m_b));
        @(posedge clk);
        #1;
        cyc++;
        check("sb_a", {9'd0, vec_a}, {9'd0, q_a.pop_front()});
        check("sb_b", {9'd0, vec_b}, {9'd0, q_b.pop_front()});
        monitor(0, vec_a);
        monitor(1, vec_b);
    endtask

    // ---------------------------------------------------------------------
    // Vector table, anchored at A's first frame_start (frame position 0)
    // ---------------------------------------------------------------------
    typedef struct {
        bit en;
        int cycles;
        bit run;
        bit sclk;
        bit lrck;
        bit fs;
        bit fall;
        int frames;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int wait_n;
        int hi_a, hi_b, up_a, up_b;
        bit pa, pb;
        bit got;

        //           en cycles   run sclk lrck fs fall frames
        tbl[0] = '{1'b1, 1024, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0};  // lrck rises at 1024
        tbl[1] = '{1'b1, 1024, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1};  // first wrap
        tbl[2] = '{1'b1, 4096, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3};  // third wrap
        tbl[3] = '{1'b1,  700, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3};  // position 700
        tbl[4] = '{1'b0,  200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3};  // draining at 900
        tbl[5] = '{1'b1, 1148, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4};  // resumed, wraps on time
        tbl[6] = '{1'b1,  700, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4};
        tbl[7] = '{1'b0, 1348, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5};  // IDLE entry, last fall
        tbl[8] = '{1'b0,  100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5};  // stays idle

        rst  = 1'b1;
        en_a = 1'b0;
        en_b = 1'b0;
        m_a  = '{default: 0};
        m_b  = '{default: 0};
        mon_reset();

        repeat (3) tick();
        check("reset_state_a", {9'd0, vec_a}, 32'd0);
        check("reset_state_b", {9'd0, vec_b}, 32'd0);
        rst = 1'b0;

        // Get into RUN, then reset asynchronously mid-frame with en low
        en_a = 1'b1;
        repeat (300) tick();
        check("running_before_reset", run_a, 1);
        en_a = 1'b0;
        rst  = 1'b1;
        #1;
        check("async_reset_a", {9'd0, vec_a}, 32'd0);
        check("async_reset_b", {9'd0, vec_b}, 32'd0);
        m_a = '{default: 0};
        m_b = '{default: 0};
        mon_reset();
        repeat (2) tick();
        rst = 1'b0;

        // mclk keeps toggling in IDLE: 50% duty, period 4 (A) and 2 (B)
        hi_a = 0; hi_b = 0; up_a = 0; up_b = 0;
        pa = mclk_a;
        pb = mclk_b;
        for (int i = 0; i < 16; i++) begin
            tick();
            hi_a += int'(mclk_a);
            hi_b += int'(mclk_b);
            if (mclk_a && !pa) up_a++;
            if (mclk_b && !pb) up_b++;
            pa = mclk_a;
            pb = mclk_b;
        end
        check("mclk_high_a", hi_a, 8);
        check("mclk_rises_a", up_a, 4);
        check("mclk_high_b", hi_b, 8);
        check("mclk_rises_b", up_b, 8);
        check("idle_sclk_lrck_run_a", {sclk_a, lrck_a, run_a}, 3'b000);

        // Start at an arbitrary mclk phase; frame_start within one mclk period
        repeat ($urandom_range(0, 3)) tick();
        en_a   = 1'b1;
        got    = 1'b0;
        wait_n = 0;
        while (!got && wait_n < 8) begin
            tick();
            wait_n++;
            got = fs_a;
        end
        check("start_fs_seen", got, 1);
        check("start_latency_le_4", (wait_n >= 1 && wait_n <= 4), 1);
        check("start_frame_cnt", fcnt_a, 0);

        for (int i = 0; i < 9; i++) begin
            en_a = tbl[i].en;
            repeat (tbl[i].cycles) tick();
            check($sformatf("tbl%0d", i),
                  {11'd0, run_a, sclk_a, lrck_a, fs_a, fall_a, fcnt_a},
                  {11'd0, tbl[i].run, tbl[i].sclk, tbl[i].lrck, tbl[i].fs, tbl[i].fall,
                   16'(tbl[i].frames)});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
